// File: rtl/hazard_if.sv
// hazard_if: ID-stage hazard query, branch resolve and pipeline-control response bundle
interface hazard_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int LAT_WIDTH  = 3,
  parameter int CNT_WIDTH  = 32
);
  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_rs1;
  logic [ADDR_WIDTH-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [ADDR_WIDTH-1:0] id_rd;
  logic                  id_regwrite;
  logic [LAT_WIDTH-1:0]  id_lat;
  logic                  resolve;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_write;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  exmem_flush;
  logic                  stall;
  logic [CNT_WIDTH-1:0]  stall_cycles;
  logic [CNT_WIDTH-1:0]  flush_events;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_lat, resolve,
    input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, stall,
    input  stall_cycles, flush_events
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite, id_lat, resolve,
    output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, stall,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register latency scoreboard driving RAW/WAW stalls, branch flushes and perf counters
module hazard_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int LAT_WIDTH  = 3,
  parameter int CNT_WIDTH  = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave bus
);
  localparam int N = 2 ** ADDR_WIDTH;
  logic [LAT_WIDTH-1:0] cnt [N];
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;
  logic raw, waw, haz, issue, ld, stall, flush;
  always_comb begin
    raw   = (bus.id_use_rs1 && bus.id_rs1 != '0 && cnt[bus.id_rs1] != '0) ||
            (bus.id_use_rs2 && bus.id_rs2 != '0 && cnt[bus.id_rs2] != '0);
    waw   = bus.id_regwrite && bus.id_rd != '0 && cnt[bus.id_rd] > bus.id_lat;
    haz   = bus.id_valid && (raw || waw);
    issue = bus.id_valid && !haz && !bus.resolve;
    ld    = issue && bus.id_regwrite && bus.id_rd != '0 && bus.id_lat != '0;
    stall = !rst && !bus.resolve && haz;
    flush = !rst && bus.resolve;
  end
  assign bus.pc_write     = !stall;
  assign bus.ifid_write   = !stall;
  assign bus.idex_write   = !stall;
  assign bus.ifid_flush   = flush;
  assign bus.idex_flush   = flush;
  assign bus.exmem_flush  = flush;
  assign bus.stall        = stall;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;
  // Issue load wins over the countdown for the destination; x0 never holds a pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) cnt[r] <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      for (int r = 0; r < N; r++)
        cnt[r] <= (r == 0) ? '0 :
                  (ld && bus.id_rd == r[ADDR_WIDTH-1:0]) ? bus.id_lat :
                  cnt[r] - LAT_WIDTH'(|cnt[r]);
      if (stall && !(&stall_q)) stall_q <= stall_q + CNT_WIDTH'(1);
      if (bus.resolve && !(&flush_q)) flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end
endmodule
